free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PRF_DEPTH, default 64, number of physical registers.
REQ-002 SHALL have parameter ARF_DEPTH, default 32, number of architectural registers; FL_DEPTH = PRF_DEPTH-ARF_DEPTH; PRF_IDX = $clog2(PRF_DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset (rst==0 at clk edge resets).
REQ-005 SHALL have port fl_valid  input  1  decode pop request, one register per cycle.
REQ-006 SHALL have port fl_ready  output  1  free list non-empty, pop will be accepted.
REQ-007 SHALL have port fl_free_idx  output  PRF_IDX  physical register at head, valid when fl_ready.
REQ-008 SHALL have port rob_push_valid  input  1  committing instruction with rd!=x0 returns its old physical register.
REQ-009 SHALL have port rob_push_idx  input  PRF_IDX  physical register being freed.
REQ-010 SHALL have port flush  input  1  mispredict recovery, discard speculative allocations.

Function
REQ-011 SHALL store indices in an FL_DEPTH-entry circular buffer with head, tail, commit_head pointers of $clog2(FL_DEPTH)+1 bits (MSB = wrap bit).
REQ-012 SHALL compute count = tail-head (modulo pointer width); empty when count==0, full when count==FL_DEPTH.
REQ-013 SHALL drive fl_ready = !empty and fl_free_idx = entry[head] combinationally from registered state only.
REQ-014 SHALL on fl_valid&&fl_ready&&!flush advance head by 1; fl_valid while !fl_ready SHALL change nothing.
REQ-015 SHALL on rob_push_valid write rob_push_idx to entry[tail], advance tail by 1, advance commit_head by 1 (pops and commits are in program order, so commit_head marks the architectural allocation point).
REQ-016 SHALL on flush set head to the next-cycle value of commit_head (including an increment from a same-cycle push); pop in the same cycle is dropped.
REQ-017 SHALL accept simultaneous pop and push in one cycle; count unchanged, both pointers advance.
REQ-018 SHALL ignore rob_push_valid when full (protocol violation) and flag it with a simulation-only assertion; no pointer moves.
REQ-019 SHALL wrap all pointers at FL_DEPTH with wrap-bit toggle; no reserved or bubble entry.
REQ-020 SHALL have pop latency zero: index presented in the same cycle as fl_ready, new head visible the next cycle.

Reset
REQ-021 SHALL on rst==0 initialize entry[i] = ARF_DEPTH+i for i in 0..FL_DEPTH-1.
REQ-022 SHALL on rst==0 set head=0, commit_head=0, tail=FL_DEPTH (wrap bit set, full).
REQ-023 SHALL after reset present fl_ready=1, fl_free_idx=ARF_DEPTH in the first cycle with rst==1.
REQ-024 SHALL give reset priority over flush, push and pop; reset mid-operation discards all outstanding allocations.

Configuration
REQ-025 SHALL recognize macro FREE_LIST_BYPASS_EN.
REQ-026 With FREE_LIST_BYPASS_EN defined: when empty and rob_push_valid, fl_ready=1 and fl_free_idx=rob_push_idx same cycle; accepted pop advances head past the newly written entry.
REQ-027 Without FREE_LIST_BYPASS_EN: fl_ready depends only on registered state; empty with same-cycle push gives fl_ready=0 until the next cycle.
REQ-028 Flush SHALL suppress the bypass pop in both builds.

Verification
REQ-029 Reset then 32 consecutive pops -> fl_free_idx 32,33,...,63 one per cycle; then fl_ready=0 and fl_valid has no effect.
REQ-030 Empty, push idx 5 -> without macro fl_ready=0 that cycle, fl_ready=1 fl_free_idx=5 next cycle; with macro fl_ready=1 fl_free_idx=5 same cycle.
REQ-031 Reset, pop 3 (32,33,34), push idx 7 (commit_head=1), flush -> next cycle fl_free_idx=33, count=32.
REQ-032 Reset, pop 1, then pop and push idx 9 same cycle for 40 cycles -> count constant 31, pointers wrap, popped sequence reproduces pushed indices in FIFO order.
REQ-033 Full (after reset), rob_push_valid=1 idx 3 -> assertion fires, tail and count unchanged, fl_free_idx=32.
REQ-034 Pops in progress, rst=0 for one cycle -> fl_free_idx=32, count=32 after reset, flush/push/pop during reset ignored.

Source files
------------

// File: rtl/free_list.sv
// free_list: circular list of free physical register indices for rename, with commit-point flush recovery.
// Optional macro FREE_LIST_BYPASS_EN forwards a committing index straight to decode when the list is empty.
module free_list #(
  parameter  int PRF_DEPTH = 64,
  parameter  int ARF_DEPTH = 32,
  localparam int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH,
  localparam int PRF_IDX   = $clog2(PRF_DEPTH),
  localparam int ADDR_W    = $clog2(FL_DEPTH),
  localparam int PTR_W     = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fl_valid,
  output logic               fl_ready,
  output logic [PRF_IDX-1:0] fl_free_idx,
  input  logic               rob_push_valid,
  input  logic [PRF_IDX-1:0] rob_push_idx,
  input  logic               flush
);

  logic [PRF_IDX-1:0] entries [FL_DEPTH];
  logic [PTR_W-1:0]   head, tail, commit_head;
  logic [PTR_W-1:0]   head_nxt, tail_nxt, commit_head_nxt;
  logic [PTR_W-1:0]   count;
  logic               empty, full, pop, push;

  // Pointer MSB is the wrap bit; low bits index the buffer and wrap at FL_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p[ADDR_W-1:0] == ADDR_W'(FL_DEPTH - 1))
      r = {~p[PTR_W-1], {ADDR_W{1'b0}}};
    else
      r = p + PTR_W'(1);
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dist(input logic [PTR_W-1:0] t,
                                                input logic [PTR_W-1:0] h);
    logic [PTR_W-1:0] r;
    if (t[PTR_W-1] == h[PTR_W-1])
      r = PTR_W'(t[ADDR_W-1:0]) - PTR_W'(h[ADDR_W-1:0]);
    else
      r = PTR_W'(FL_DEPTH) + PTR_W'(t[ADDR_W-1:0]) - PTR_W'(h[ADDR_W-1:0]);
    return r;
  endfunction

  assign count = ptr_dist(tail, head);
  assign empty = (count == '0);
  assign full  = (count == PTR_W'(FL_DEPTH));

`ifdef FREE_LIST_BYPASS_EN
  // When empty, a committing index can be handed to decode in the same cycle it is written.
  assign fl_ready    = !empty || rob_push_valid;
  assign fl_free_idx = empty ? rob_push_idx : entries[head[ADDR_W-1:0]];
`else
  assign fl_ready    = !empty;
  assign fl_free_idx = entries[head[ADDR_W-1:0]];
`endif

  assign pop  = fl_valid && fl_ready && !flush;
  assign push = rob_push_valid && !full;

  always_comb begin
    tail_nxt        = tail;
    commit_head_nxt = commit_head;
    head_nxt        = head;
    if (push) begin
      tail_nxt        = ptr_inc(tail);
      commit_head_nxt = ptr_inc(commit_head);
    end
    // Recovery rewinds to the architectural allocation point, including this cycle's commit.
    if (flush)
      head_nxt = commit_head_nxt;
    else if (pop)
      head_nxt = ptr_inc(head);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= {1'b1, {ADDR_W{1'b0}}};
    end else begin
      head        <= head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entries[i] <= PRF_IDX'(ARF_DEPTH + i);
    end else if (push) begin
      entries[tail[ADDR_W-1:0]] <= rob_push_idx;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst)
      assert (!(rob_push_valid && full))
        else $warning("free_list: push to a full free list ignored");
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboarded bench for free_list: the driver queues expected per-cycle outputs, a negedge monitor checks them.
module tb_free_list;
  localparam int PRF_IDX = 6;

  logic               clk;
  logic               rst;
  logic               fl_valid;
  logic               fl_ready;
  logic [PRF_IDX-1:0] fl_free_idx;
  logic               rob_push_valid;
  logic [PRF_IDX-1:0] rob_push_idx;
  logic               flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string              name;
    bit                 rdy;
    logic [PRF_IDX-1:0] idx;
    int                 cnt;
  } exp_t;

  exp_t exp_q[$];

`ifdef FREE_LIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  free_list dut (
    .clk            (clk),
    .rst            (rst),
    .fl_valid       (fl_valid),
    .fl_ready       (fl_ready),
    .fl_free_idx    (fl_free_idx),
    .rob_push_valid (rob_push_valid),
    .rob_push_idx   (rob_push_idx),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the current cycle's outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (fl_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s fl_ready got %0b want %0b", e.name, fl_ready, e.rdy);
      end
      if (e.rdy) begin
        checks++;
        if (fl_free_idx !== e.idx) begin
          errors++;
          $display("FAIL %s fl_free_idx got %0d want %0d", e.name, fl_free_idx, e.idx);
        end
      end
      if (e.cnt >= 0) begin
        checks++;
        if (int'(dut.count) != e.cnt) begin
          errors++;
          $display("FAIL %s count got %0d want %0d", e.name, dut.count, e.cnt);
        end
      end
    end
  end

  task automatic step(input bit v, input bit pv, input int pidx, input bit fl,
                      input bit chk, input string nm, input bit rdy, input int idx,
                      input int cnt);
    exp_t e;
    fl_valid       = v;
    rob_push_valid = pv;
    rob_push_idx   = PRF_IDX'(pidx);
    flush          = fl;
    if (chk) begin
      e.name = nm;
      e.rdy  = rdy;
      e.idx  = PRF_IDX'(idx);
      e.cnt  = cnt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, "", 1'b0, 0, -1);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    fl_valid       = 1'b0;
    rob_push_valid = 1'b0;
    rob_push_idx   = '0;
    flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state, then drain all 32 initial entries.
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "reset_state", 1'b1, 32, 32);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, "drain_pop", 1'b1, 32 + i, 32 - i);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "empty_pop_ignored", 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "empty_still", 1'b0, 0, 0);

    // Push into an empty list, with and without a same-cycle pop.
    step(1'b0, 1'b1, 5, 1'b0, 1'b1, "empty_push5", BYP, 5, 0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_push5", 1'b1, 5, 1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "pop5", 1'b1, 5, 1);
    step(1'b1, 1'b1, 6, 1'b0, 1'b1, "empty_push6_pop", BYP, 6, 0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_push6_pop", !BYP, 6, BYP ? 0 : 1);

    // Flush rewinds head to commit_head.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, "flush_pre_pop", 1'b1, 32 + i, 32 - i);
    step(1'b0, 1'b1, 7, 1'b0, 1'b1, "push7", 1'b1, 35, 29);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, "flush_with_pop", 1'b1, 35, 30);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_flush", 1'b1, 33, 32);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "post_flush_pop33", 1'b1, 33, 32);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "post_flush_pop34", 1'b1, 34, 31);
    step(1'b0, 1'b1, 11, 1'b1, 1'b1, "flush_and_push11", 1'b1, 35, 30);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_flush_push", 1'b1, 34, 32);

    // Steady-state pop+push, pointers wrap.
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "wrap_first_pop", 1'b1, 32, 32);
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'b1, 9, 1'b0, 1'b1, "wrap_pop_push", 1'b1, (k < 31) ? 33 + k : 9, 31);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "wrap_end", 1'b1, 9, 31);

    // Push while full is dropped.
    do_reset();
    step(1'b0, 1'b1, 3, 1'b0, 1'b1, "full_push3", 1'b1, 32, 32);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_full_push", 1'b1, 32, 32);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "full_then_pop", 1'b1, 32, 32);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "full_then_pop_next", 1'b1, 33, 31);

    // Reset mid-operation with every other input active.
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "midrst_pop", 1'b1, 33, 31);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "midrst_pop", 1'b1, 34, 30);
    rst = 1'b0;
    step(1'b1, 1'b1, 13, 1'b1, 1'b0, "", 1'b0, 0, -1);
    rst = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_midrst", 1'b1, 32, 32);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1, "after_midrst_pop", 1'b1, 32, 32);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, "after_midrst_next", 1'b1, 33, 31);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
